// File: rtl/tc_pkg.sv
// Shared definitions for the multi-channel timer/counter: FSM states,
// mode codes, register offsets and CTRL field positions.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_EXP  = 2'd3
    } tc_state_t;

    // MODE field codes; 1x is reserved and behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Register select (word offset within a channel's 16-byte window)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM       = 3;
    localparam int unsigned CTRL_PS_LSB   = 4;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and the
// IDLE/LOAD/CNT/EXP control FSM. Read data is presented zero-extended.
module tc_channel
    import tc_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PS_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ctrl_we,
    input  logic        i_preset_we,
    input  logic        i_status_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_preset,
    output logic [31:0] o_count,
    output logic [31:0] o_status,
    output logic        o_irq
);

    tc_state_t        r_state;
    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic [PS_W-1:0]  r_pscnt;
    logic             r_pend;
    logic             w_periodic;

    assign w_periodic = (r_mode == MODE_PERIODIC);

    // Register writes and FSM; later assignments in this block take priority,
    // so an expiry's PEND set overrides a simultaneous W1C, and a CTRL write
    // overrides the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_en     <= 1'b0;
            r_mode   <= MODE_ONESHOT;
            r_im     <= 1'b0;
            r_ps     <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_pscnt  <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (i_preset_we) begin
                r_preset <= i_wdata[CNT_W-1:0];
            end

            if (i_ctrl_we) begin
                r_en   <= i_wdata[CTRL_EN];
                r_mode <= i_wdata[CTRL_MODE_LSB +: 2];
                r_im   <= i_wdata[CTRL_IM];
                r_ps   <= i_wdata[CTRL_PS_LSB +: PS_W];
            end else if (r_state == ST_EXP && !w_periodic) begin
                r_en <= 1'b0;
            end

            if (i_status_we && i_wdata[0]) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_pscnt <= '0;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_en) begin
                        r_state <= ST_IDLE;
                    end else if (r_pscnt == r_ps) begin
                        r_pscnt <= '0;
                        if (r_count > CNT_W'(1)) begin
                            r_count <= r_count - CNT_W'(1);
                        end else begin
                            r_count <= '0;
                            r_pend  <= 1'b1;
                            r_state <= ST_EXP;
                        end
                    end else begin
                        r_pscnt <= r_pscnt + PS_W'(1);
                    end
                end
                ST_EXP: begin
                    if (w_periodic && r_en) begin
                        r_count <= r_preset;
                        r_pscnt <= '0;
                        r_state <= ST_CNT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Zero-extended read views of the channel registers
    always_comb begin
        o_ctrl                          = '0;
        o_ctrl[CTRL_EN]                 = r_en;
        o_ctrl[CTRL_MODE_LSB +: 2]      = r_mode;
        o_ctrl[CTRL_IM]                 = r_im;
        o_ctrl[CTRL_PS_LSB +: PS_W]     = r_ps;
        o_preset                        = '0;
        o_preset[CNT_W-1:0]             = r_preset;
        o_count                         = '0;
        o_count[CNT_W-1:0]              = r_count;
        o_status                        = '0;
        o_status[0]                     = r_pend;
    end

    assign o_irq = r_pend & r_im;

endmodule

// File: rtl/tc_multi.sv
// Multi-channel timer/counter: bus address decode, read mux and IRQ
// aggregation around N_CH independent tc_channel instances.
module tc_multi
    import tc_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PS_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic [N_CH-1:0] IRQ,
    output logic            IRQ_ANY
);

    logic [2:0]  w_ch;
    logic [1:0]  w_reg;
    logic [31:0] w_ctrl   [N_CH];
    logic [31:0] w_preset [N_CH];
    logic [31:0] w_count  [N_CH];
    logic [31:0] w_status [N_CH];
    logic        w_unused;

    assign w_ch     = Addr[6:4];
    assign w_reg    = Addr[3:2];
    assign w_unused = ^Addr[31:7];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic w_sel;
        assign w_sel = WE && (w_ch == 3'(k));

        tc_channel #(
            .CNT_W (CNT_W),
            .PS_W  (PS_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_ctrl_we   (w_sel && (w_reg == REG_CTRL)),
            .i_preset_we (w_sel && (w_reg == REG_PRESET)),
            .i_status_we (w_sel && (w_reg == REG_STATUS)),
            .i_wdata     (Din),
            .o_ctrl      (w_ctrl[k]),
            .o_preset    (w_preset[k]),
            .o_count     (w_count[k]),
            .o_status    (w_status[k]),
            .o_irq       (IRQ[k])
        );
    end

    // Read mux; channel indices with no instance never match and read 0
    always_comb begin
        Dout = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (w_ch == 3'(k)) begin
                case (w_reg)
                    REG_CTRL:   Dout = w_ctrl[k];
                    REG_PRESET: Dout = w_preset[k];
                    REG_COUNT:  Dout = w_count[k];
                    default:    Dout = w_status[k];
                endcase
            end
        end
    end

    assign IRQ_ANY = |IRQ;

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Parametrised multi-channel timer/counter on the CPU's memory-mapped peripheral bus.
- Successor to the single-channel TC. Adds:
  - N independent channels
  - a per-channel prescaler
  - true auto-reload periodic mode
  - a sticky write-1-to-clear pending bit per channel
  - a per-channel IRQ vector plus an aggregated IRQ
- Sits behind the system bridge; IRQ outputs feed the CP0 interrupt-pending inputs.

Parameters:
- N_CH, 4: number of channels (1..8).
- CNT_W, 32: counter/preset width in bits (8..32); upper Dout bits read 0.
- PS_W, 8: prescaler field width (1..8).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted; asynchronous assertion).
- Addr  in  30 (bits 31:2)  word address. Addr[3:2] selects the register; Addr[6:4] selects the channel.
- WE  in  1  write enable for the addressed register this cycle.
- Din  in  32  write data.
- Dout  out  32  combinational read data of the addressed register.
- IRQ  out  N_CH  per-channel interrupt, IRQ[k] = PEND[k] & IM[k].
- IRQ_ANY  out  1  OR of IRQ.

Behaviour:
- Register map, channel k at byte offset k*0x10:
  - 0x0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM, bits(4+PS_W-1):4 PS; other bits read 0.
  - 0x4 PRESET: CNT_W bits.
  - 0x8 COUNT: read-only; writes ignored.
  - 0xC STATUS: bit0 PEND, write-1-to-clear; writing 0 has no effect.
- Address decode: a channel index >= N_CH reads 0 and ignores writes.
- Modes:
  - 00 one-shot
  - 01 periodic auto-reload
  - 1x reserved, treated as one-shot
- Reset (reset low, asynchronous): all CTRL/PRESET/COUNT/PEND/prescale counters = 0, all states IDLE, IRQ = 0, IRQ_ANY = 0.
- Per-channel FSM (states IDLE, LOAD, CNT, EXP):
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET; prescale counter <= 0 -> CNT.
  - CNT with EN=0: -> IDLE; COUNT holds its value.
  - CNT with EN=1:
    - The prescale counter increments each cycle.
    - A tick occurs when the prescale counter == PS; the counter then returns to 0.
    - On a tick: if COUNT > 1, COUNT <= COUNT-1. Otherwise COUNT <= 0, PEND <= 1, -> EXP.
  - EXP, one-shot: EN <= 0 -> IDLE.
  - EXP, periodic with EN=1: COUNT <= PRESET, prescale counter <= 0 -> CNT.
  - EXP, periodic with EN=0: -> IDLE.
- Timing:
  - First expiry, with the CTRL write at edge 0: PEND rises after edge PRESET*(PS+1)+2.
  - Periodic period: PRESET*(PS+1)+1 cycles.
- PRESET = 0 behaves as PRESET = 1.
- Bus writes and counting:
  - A bus write never stalls any channel's counting. This differs from TC.
  - A CTRL write takes effect from the next cycle.
  - A PRESET write mid-count affects only the next LOAD or reload.
- Same cycle as expiry:
  - A CTRL write in the EXP cycle wins over the one-shot EN clear.
  - PEND set by expiry wins over a simultaneous W1C.
- Clearing EN mid-count: the channel stops and PEND is unchanged. Re-setting EN restarts from LOAD.
- Clearing IM masks IRQ[k] but PEND still sets.
- COUNT arithmetic is CNT_W wide, with no wrap below 0.
- Channels are fully independent; no shared state except the bus decode.

Decomposition:
- Package tc_pkg:
  - state encodings
  - MODE codes
  - register offsets
  - CTRL bit positions (EN, MODE, IM, PS_LSB)
- Sub-module tc_channel: one FSM plus prescaler plus registers, instantiated N_CH times by generate.
- Top level: address decode, Dout mux, IRQ_ANY reduction.

Test Plan:
- One-shot, ch0: PRESET=3, CTRL=0x9 (EN, IM, mode 00).
  - PEND and IRQ[0] rise 5 cycles after the write edge.
  - COUNT sequence reads 3, 2, 1, 0; CTRL.EN reads 0 afterwards.
- Periodic, ch2: PRESET=4, PS=1, CTRL=0x1B.
  - First PEND after 10 cycles.
  - After a W1C, PEND re-sets 9 cycles after the prior expiry; repeats 3 times.
- Collision: W1C to STATUS in the same cycle as an expiry -> PEND stays 1.
  - A lone W1C clears PEND and IRQ the next cycle.
- Independence: ch1 and ch3 run with different PRESET values while the CPU writes ch0 every cycle.
  - ch1 and ch3 expiry times are unchanged.
  - IRQ_ANY is the OR of both.
- Reset mid-count: reset low at COUNT=7.
  - All registers, IRQ and IRQ_ANY = 0 immediately, without waiting for a clock edge.
  - Counting resumes only after a new CTRL write.
- Decode: with N_CH=4, access channel 5 -> reads 0 and writes have no effect. A write to COUNT is ignored.
